// File: rtl/racing_game_v3_pkg.sv
// Shared timing, geometry and palette constants for the v3 racing game.
// Also holds the sprite hit/row/col helper used for both cars.
package racing_game_v3_pkg;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FP      = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_TOTAL   = 10'd800;
    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FP      = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_TOTAL   = 10'd525;

    localparam logic [9:0] TRACK_L = 10'd64;
    localparam logic [9:0] TRACK_R = 10'd576;
    localparam logic [9:0] DASH_L  = 10'd316;
    localparam logic [9:0] DASH_R  = 10'd323;

    localparam logic [9:0] PLAYER_Y     = 10'd400;
    localparam logic [9:0] PLAYER_X0    = 10'd312;
    localparam logic [9:0] PLAYER_X_MIN = 10'd64;
    localparam logic [9:0] PLAYER_X_MAX = 10'd560;
    localparam logic [9:0] ENEMY_X      = 10'd200;
    localparam logic [9:0] ENEMY_STEP   = 10'd2;
    localparam logic [9:0] SCROLL_STEP  = 10'd2;
    localparam logic [9:0] CAR_W        = 10'd16;
    localparam logic [9:0] CAR_H        = 10'd32;

    typedef logic [2:0] rgb_t;
    localparam rgb_t RGB_BLACK  = 3'b000;
    localparam rgb_t RGB_GRASS  = 3'b010;
    localparam rgb_t RGB_DASH   = 3'b111;
    localparam rgb_t RGB_PLAYER = 3'b110;
    localparam rgb_t RGB_ENEMY  = 3'b100;

    typedef struct packed {
        logic       hit;
        logic [3:0] row;
        logic [2:0] col;
    } sprite_t;

    // Range check first so the subtraction never underflows.
    function automatic sprite_t sprite_at(
        input logic [9:0] h,
        input logic [9:0] v,
        input logic [9:0] cx,
        input logic [9:0] cy
    );
        sprite_t s;
        s.hit = (h >= cx) && (h < cx + CAR_W) &&
                (v >= cy) && (v < cy + CAR_H);
        s.row = s.hit ? 4'((v - cy) >> 1) : 4'd0;
        s.col = s.hit ? 3'((h - cx) >> 1) : 3'd0;
        return s;
    endfunction

endpackage

// File: rtl/car_bitmap.sv
// 8x16 car bitmap with two asynchronous read ports.
// Contents are loaded from outside the design (car.hex image).
module car_bitmap
(
    input  logic [3:0] p_row,
    input  logic [2:0] p_col,
    output logic       p_bit,
    input  logic [3:0] e_row,
    input  logic [2:0] e_col,
    output logic       e_bit
);

    logic [7:0] bitarray [0:15];

    assign p_bit = bitarray[p_row][3'd7 - p_col];
    assign e_bit = bitarray[e_row][3'd7 - e_col];

endmodule

// File: rtl/racing_game_top_v3.sv
// Raster counters, per-frame game state and the registered pixel mux.
// Counters and game state advance only when pix_en (clk_div) is high.
module racing_game_top_v3
    import racing_game_v3_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic [1:0] keys,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb
);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic [9:0] player_x_q, player_x_d;
    logic [9:0] enemy_y_q, enemy_y_d;
    logic [9:0] scroll_q, scroll_d;
    logic       coll_q, coll_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    rgb_t       rgb_q, rgb_d;

    sprite_t    ps, es;
    logic       p_bit, e_bit;
    logic       frame_tick, visible, p_on, e_on, grass, dash_on;
    logic [9:0] enemy_next;

    assign ps = sprite_at(hpos_q, vpos_q, player_x_q, PLAYER_Y);
    assign es = sprite_at(hpos_q, vpos_q, ENEMY_X, enemy_y_q);

    car_bitmap car (
        .p_row (ps.row),
        .p_col (ps.col),
        .p_bit (p_bit),
        .e_row (es.row),
        .e_col (es.col),
        .e_bit (e_bit)
    );

    always_comb begin
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        if (pix_en) begin
            if (hpos_q == H_TOTAL - 10'd1) begin
                hpos_d = 10'd0;
                vpos_d = (vpos_q == V_TOTAL - 10'd1) ? 10'd0 : vpos_q + 10'd1;
            end else begin
                hpos_d = hpos_q + 10'd1;
            end
        end

        frame_tick = pix_en && (hpos_q == 10'd0) && (vpos_q == V_VISIBLE);
        visible    = (hpos_q < H_VISIBLE) && (vpos_q < V_VISIBLE);
        p_on       = ps.hit && p_bit;
        e_on       = es.hit && e_bit;
        grass      = (hpos_q < TRACK_L) || (hpos_q >= TRACK_R);
        dash_on    = (hpos_q >= DASH_L) && (hpos_q <= DASH_R) &&
                     1'((vpos_q + scroll_q) >> 4);

        rgb_d = RGB_BLACK;
        if (!visible)     rgb_d = RGB_BLACK;
        else if (p_on)    rgb_d = RGB_PLAYER;
        else if (e_on)    rgb_d = RGB_ENEMY;
        else if (grass)   rgb_d = RGB_GRASS;
        else if (dash_on) rgb_d = RGB_DASH;

        hsync_d = !((hpos_q >= H_VISIBLE + H_FP) &&
                    (hpos_q <  H_VISIBLE + H_FP + H_SYNC));
        vsync_d = !((vpos_q >= V_VISIBLE + V_FP) &&
                    (vpos_q <  V_VISIBLE + V_FP + V_SYNC));

        enemy_next = enemy_y_q + ENEMY_STEP;
        player_x_d = player_x_q;
        enemy_y_d  = enemy_y_q;
        scroll_d   = scroll_q;
        coll_d     = coll_q || (visible && p_on && e_on);

        // A collision pending at the frame tick overrides steering.
        if (frame_tick) begin
            coll_d    = 1'b0;
            enemy_y_d = (enemy_next >= V_VISIBLE) ? 10'd0 : enemy_next;
            scroll_d  = scroll_q - SCROLL_STEP;
            if (coll_q)
                player_x_d = PLAYER_X0;
            else if (keys == 2'b10 && player_x_q < PLAYER_X_MAX)
                player_x_d = player_x_q + 10'd1;
            else if (keys == 2'b01 && player_x_q > PLAYER_X_MIN)
                player_x_d = player_x_q - 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q     <= 10'd0;
            vpos_q     <= 10'd0;
            player_x_q <= PLAYER_X0;
            enemy_y_q  <= 10'd0;
            scroll_q   <= 10'd0;
            coll_q     <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            rgb_q      <= RGB_BLACK;
        end else begin
            hpos_q     <= hpos_d;
            vpos_q     <= vpos_d;
            player_x_q <= player_x_d;
            enemy_y_q  <= enemy_y_d;
            scroll_q   <= scroll_d;
            coll_q     <= coll_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            rgb_q      <= rgb_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign rgb   = rgb_q;

endmodule

// File: rtl/racing_game_v3_wrapper.sv
// Top wrapper: divides clk by two for the pixel rate and hosts the game core.
// Only the left/right keys are used; the upper two are ignored.
module racing_game_v3_wrapper
    import racing_game_v3_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keys,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb
);

    logic clk_div;
    logic clk_div_d;
    logic keys_unused;

    assign clk_div_d   = !clk_div;
    assign keys_unused = ^keys[3:2];

    always_ff @(posedge clk) begin
        if (reset) clk_div <= 1'b0;
        else       clk_div <= clk_div_d;
    end

    racing_game_top_v3 racing_game_top_v3_0 (
        .clk    (clk),
        .reset  (reset),
        .pix_en (clk_div),
        .keys   (keys[1:0]),
        .hsync  (hsync),
        .vsync  (vsync),
        .rgb    (rgb)
    );

endmodule

// File: tb/tb_racing_game_v3_wrapper.sv
// Directed bench for racing_game_v3_wrapper; raster position is jumped by
// forcing the counters for one non-advancing clock so frames stay short.
module tb_racing_game_v3_wrapper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keys = 4'd0;
    logic       hsync, vsync;
    logic [2:0] rgb;

    int checks = 0;
    int failures = 0;
    int fc = 0;
    int hs_low, hs_first, vs_low;
    logic [9:0] jh, jv;

    logic [7:0] tbl [0:16-1] = '{
        8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hBD, 8'hBD, 8'hFF, 8'h7E,
        8'h3C, 8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hBD, 8'h81, 8'h81
    };

    racing_game_v3_wrapper dut (
        .clk   (clk),
        .reset (reset),
        .keys  (keys),
        .hsync (hsync),
        .vsync (vsync),
        .rgb   (rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Park counters at (h,v) across one non-tick edge; outputs then show (h,v).
    task jump(input logic [9:0] h, input logic [9:0] v);
        @(negedge clk);
        if (dut.clk_div) @(negedge clk);
        jh = h;
        jv = v;
        force dut.racing_game_top_v3_0.hpos_q = jh;
        force dut.racing_game_top_v3_0.vpos_q = jv;
        @(posedge clk);
        @(negedge clk);
        release dut.racing_game_top_v3_0.hpos_q;
        release dut.racing_game_top_v3_0.vpos_q;
    endtask

    task pix(input logic [9:0] h, input logic [9:0] v,
             input logic [2:0] exp, input string tag);
        jump(h, v);
        chk(tag, rgb, exp);
    endtask

    task frame();
        jump(10'd0, 10'd480);
        @(negedge clk);
        fc++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            dut.racing_game_top_v3_0.car.bitarray[i] = tbl[i];

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_rgb", rgb, 0);
        chk("rst_px", dut.racing_game_top_v3_0.player_x_q, 312);
        chk("rst_ey", dut.racing_game_top_v3_0.enemy_y_q, 0);
        chk("rst_scroll", dut.racing_game_top_v3_0.scroll_q, 0);
        reset = 1'b0;

        @(negedge clk);
        chk("first_rise", dut.clk_div, 1);
        hs_low = 0;
        hs_first = -1;
        vs_low = 0;
        for (int p = 0; p < 800; p++) begin
            if (!hsync) begin
                if (hs_first < 0) hs_first = p;
                hs_low++;
            end
            if (!vsync) vs_low++;
            case (p)
                0:   chk("l0_p0", rgb, 3'b010);
                63:  chk("l0_p63", rgb, 3'b010);
                64:  chk("l0_p64", rgb, 3'b000);
                200: chk("l0_enemy_off", rgb, 3'b000);
                206: chk("l0_enemy_on", rgb, 3'b100);
                210: chk("l0_enemy_c5", rgb, 3'b000);
                320: chk("l0_dash", rgb, 3'b000);
                575: chk("l0_p575", rgb, 3'b000);
                576: chk("l0_p576", rgb, 3'b010);
                639: chk("l0_p639", rgb, 3'b010);
                640: chk("l0_p640", rgb, 3'b000);
                default: ;
            endcase
            repeat (2) @(negedge clk);
        end
        chk("hs_low_cnt", hs_low, 96);
        chk("hs_first", hs_first, 656);
        chk("vs_low_l0", vs_low, 0);
        chk("line1_h", dut.racing_game_top_v3_0.hpos_q, 0);
        chk("line1_v", dut.racing_game_top_v3_0.vpos_q, 1);

        pix(10'd700, 10'd100, 3'b000, "blank_700_100");
        pix(10'd316, 10'd16, 3'b111, "dash_316");
        pix(10'd315, 10'd16, 3'b000, "dash_315");
        pix(10'd323, 10'd16, 3'b111, "dash_323");
        pix(10'd324, 10'd16, 3'b000, "dash_324");
        pix(10'd312, 10'd400, 3'b000, "pl_r0c0");
        pix(10'd318, 10'd400, 3'b110, "pl_r0c3");
        pix(10'd312, 10'd406, 3'b110, "pl_r3c0");
        pix(10'd326, 10'd428, 3'b110, "pl_r14c7");
        pix(10'd314, 10'd408, 3'b000, "pl_r4c1");
        pix(10'd311, 10'd400, 3'b000, "pl_left_out");
        pix(10'd328, 10'd400, 3'b000, "pl_right_out");

        jump(10'd0, 10'd489);
        chk("vs_489", vsync, 1);
        jump(10'd0, 10'd490);
        chk("vs_490", vsync, 0);
        jump(10'd0, 10'd491);
        chk("vs_491", vsync, 0);
        jump(10'd0, 10'd492);
        chk("vs_492", vsync, 1);
        jump(10'd799, 10'd524);
        repeat (2) @(negedge clk);
        chk("wrap_h", dut.racing_game_top_v3_0.hpos_q, 0);
        chk("wrap_v", dut.racing_game_top_v3_0.vpos_q, 0);
        chk("wrap_rgb", rgb, 3'b010);

        frame();
        chk("f1_px", dut.racing_game_top_v3_0.player_x_q, 312);
        chk("f1_ey", dut.racing_game_top_v3_0.enemy_y_q, 2);
        chk("f1_scroll", dut.racing_game_top_v3_0.scroll_q, 1022);
        pix(10'd320, 10'd16, 3'b000, "dash_shift_16");
        pix(10'd320, 10'd18, 3'b111, "dash_shift_18");

        keys = 4'b0010;
        repeat (40) frame();
        chk("f41_px", dut.racing_game_top_v3_0.player_x_q, 352);
        chk("f41_ey", dut.racing_game_top_v3_0.enemy_y_q, 82);
        repeat (300) begin
            frame();
            if (fc == 239) chk("f239_ey", dut.racing_game_top_v3_0.enemy_y_q, 478);
            if (fc == 240) chk("f240_ey", dut.racing_game_top_v3_0.enemy_y_q, 0);
        end
        chk("right_clamp", dut.racing_game_top_v3_0.player_x_q, 560);
        chk("f341_scroll", dut.racing_game_top_v3_0.scroll_q, 342);

        keys = 4'b0001;
        repeat (10) frame();
        chk("left10", dut.racing_game_top_v3_0.player_x_q, 550);
        keys = 4'b0011;
        frame();
        chk("both_keys", dut.racing_game_top_v3_0.player_x_q, 550);
        keys = 4'b0001;
        repeat (500) frame();
        chk("left_clamp", dut.racing_game_top_v3_0.player_x_q, 64);

        keys = 4'b0010;
        repeat (136) frame();
        keys = 4'b0000;
        repeat (172) frame();
        chk("pre_coll_px", dut.racing_game_top_v3_0.player_x_q, 200);
        chk("pre_coll_ey", dut.racing_game_top_v3_0.enemy_y_q, 400);
        pix(10'd206, 10'd400, 3'b110, "coll_pixel");
        chk("coll_set", dut.racing_game_top_v3_0.coll_q, 1);
        keys = 4'b0010;
        frame();
        chk("coll_px_reset", dut.racing_game_top_v3_0.player_x_q, 312);
        chk("coll_clear", dut.racing_game_top_v3_0.coll_q, 0);
        keys = 4'b0001;
        frame();
        chk("post_coll_left", dut.racing_game_top_v3_0.player_x_q, 311);

        jump(10'd660, 10'd490);
        chk("pre_rst_hs", hsync, 0);
        chk("pre_rst_vs", vsync, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_hs", hsync, 1);
        chk("mid_rst_vs", vsync, 1);
        chk("mid_rst_rgb", rgb, 0);
        chk("mid_rst_h", dut.racing_game_top_v3_0.hpos_q, 0);
        chk("mid_rst_v", dut.racing_game_top_v3_0.vpos_q, 0);
        chk("mid_rst_px", dut.racing_game_top_v3_0.player_x_q, 312);
        chk("mid_rst_ey", dut.racing_game_top_v3_0.enemy_y_q, 0);
        chk("mid_rst_scroll", dut.racing_game_top_v3_0.scroll_q, 0);
        chk("mid_rst_div", dut.clk_div, 0);
        reset = 1'b0;
        keys = 4'b0000;
        @(negedge clk);
        chk("post_rst_p00", rgb, 3'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
